ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/hack_kbd_pkg.sv | 90 +++++++++
 rtl/ps2_frame_rx.sv | 98 +++++++++
 rtl/ps2_key_decoder.sv | 78 +++++++
 tb/tb_ps2_key_decoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_kbd_pkg.sv
// Shared constants for the PS/2 keyboard front end: Hack key codes, PS/2 prefixes,
// shift scan codes, the frame FSM state type and the scan-code to Hack translation.
package hack_kbd_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;

  localparam logic [7:0] KEY_NEWLINE   = 8'd128;
  localparam logic [7:0] KEY_BACKSPACE = 8'd129;
  localparam logic [7:0] KEY_LEFT      = 8'd130;
  localparam logic [7:0] KEY_UP        = 8'd131;
  localparam logic [7:0] KEY_RIGHT     = 8'd132;
  localparam logic [7:0] KEY_DOWN      = 8'd133;
  localparam logic [7:0] KEY_HOME      = 8'd134;
  localparam logic [7:0] KEY_END       = 8'd135;
  localparam logic [7:0] KEY_PGUP      = 8'd136;
  localparam logic [7:0] KEY_PGDN      = 8'd137;
  localparam logic [7:0] KEY_INSERT    = 8'd138;
  localparam logic [7:0] KEY_DELETE    = 8'd139;
  localparam logic [7:0] KEY_ESC       = 8'd140;
  localparam logic [7:0] KEY_F1        = 8'd141;

  // Returns 0 for any code without a Hack equivalent.
  function automatic logic [7:0] scan_to_hack(input logic ext, input logic [7:0] sc,
                                              input logic shift);
    logic [7:0] code;
    code = 8'd0;
    if (ext) begin
      case (sc)
        8'h6B: code = KEY_LEFT;
        8'h75: code = KEY_UP;
        8'h74: code = KEY_RIGHT;
        8'h72: code = KEY_DOWN;
        8'h6C: code = KEY_HOME;
        8'h69: code = KEY_END;
        8'h7D: code = KEY_PGUP;
        8'h7A: code = KEY_PGDN;
        8'h70: code = KEY_INSERT;
        8'h71: code = KEY_DELETE;
        default: code = 8'd0;
      endcase
    end else begin
      case (sc)
        8'h1C: code = 8'd97;  8'h32: code = 8'd98;  8'h21: code = 8'd99;
        8'h23: code = 8'd100; 8'h24: code = 8'd101; 8'h2B: code = 8'd102;
        8'h34: code = 8'd103; 8'h33: code = 8'd104; 8'h43: code = 8'd105;
        8'h3B: code = 8'd106; 8'h42: code = 8'd107; 8'h4B: code = 8'd108;
        8'h3A: code = 8'd109; 8'h31: code = 8'd110; 8'h44: code = 8'd111;
        8'h4D: code = 8'd112; 8'h15: code = 8'd113; 8'h2D: code = 8'd114;
        8'h1B: code = 8'd115; 8'h2C: code = 8'd116; 8'h3C: code = 8'd117;
        8'h2A: code = 8'd118; 8'h1D: code = 8'd119; 8'h22: code = 8'd120;
        8'h35: code = 8'd121; 8'h1A: code = 8'd122;
        8'h16: code = shift ? 8'd33 : 8'd49;
        8'h1E: code = shift ? 8'd64 : 8'd50;
        8'h26: code = shift ? 8'd35 : 8'd51;
        8'h25: code = shift ? 8'd36 : 8'd52;
        8'h2E: code = shift ? 8'd37 : 8'd53;
        8'h36: code = shift ? 8'd94 : 8'd54;
        8'h3D: code = shift ? 8'd38 : 8'd55;
        8'h3E: code = shift ? 8'd42 : 8'd56;
        8'h46: code = shift ? 8'd40 : 8'd57;
        8'h45: code = shift ? 8'd41 : 8'd48;
        8'h29: code = 8'd32;
        8'h5A: code = KEY_NEWLINE;
        8'h66: code = KEY_BACKSPACE;
        8'h76: code = KEY_ESC;
        8'h05: code = KEY_F1;
        8'h06: code = KEY_F1 + 8'd1;
        8'h04: code = KEY_F1 + 8'd2;
        8'h0C: code = KEY_F1 + 8'd3;
        8'h03: code = KEY_F1 + 8'd4;
        8'h0B: code = KEY_F1 + 8'd5;
        8'h83: code = KEY_F1 + 8'd6;
        8'h0A: code = KEY_F1 + 8'd7;
        8'h01: code = KEY_F1 + 8'd8;
        8'h09: code = KEY_F1 + 8'd9;
        8'h78: code = KEY_F1 + 8'd10;
        8'h07: code = KEY_F1 + 8'd11;
        default: code = 8'd0;
      endcase
      if (shift && code >= 8'd97 && code <= 8'd122) code = code - 8'd32;
    end
    return code;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 byte receiver: line synchronisers, falling-edge detect, 11-bit frame FSM
// and inter-edge timeout. Emits accepted bytes as a one-cycle strobe.
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (0 on a falling edge)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | next edge carries the odd-parity bit
//   ST_STOP   | next edge carries the stop bit; byte checked here
module ps2_frame_rx
  import hack_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_stb,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  frame_state_t   r_state, w_next;
  logic [1:0]     r_clk_sync, r_data_sync;
  logic           r_clk_prev;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_parity;
  logic [TW-1:0]  r_tmo;
  logic           r_byte_stb, r_frame_err;
  logic           w_fall, w_bit, w_accept, w_err;

  assign w_fall = r_clk_prev & ~r_clk_sync[1];
  assign w_bit  = r_data_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_tmo       <= '0;
      r_byte_stb  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_clk_prev  <= r_clk_sync[1];
      r_state     <= w_next;
      r_byte_stb  <= w_accept;
      r_frame_err <= w_err;
      if (w_fall) begin
        r_tmo <= TW'(TIMEOUT_CYCLES - 1);
        case (r_state)
          ST_IDLE:   r_bit_cnt <= '0;
          ST_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          ST_PARITY: r_parity <= w_bit;
          default:   ;
        endcase
      end else if (r_state != ST_IDLE && r_tmo != '0) begin
        r_tmo <= r_tmo - TW'(1);
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_fall && !w_bit) w_next = ST_DATA;
      ST_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_next = ST_PARITY;
      ST_PARITY: if (w_fall) w_next = ST_STOP;
      ST_STOP: begin
        if (w_fall) begin
          w_next = ST_IDLE;
          if (w_bit && ^{r_shift, r_parity}) w_accept = 1'b1;
          else                               w_err    = 1'b1;
        end
      end
      default:   w_next = ST_IDLE;
    endcase
    // Silence mid-frame abandons the byte without flagging an error.
    if (r_state != ST_IDLE && !w_fall && r_tmo == '0) w_next = ST_IDLE;
  end

  assign o_byte      = r_shift;
  assign o_byte_stb  = r_byte_stb;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard to Hack key-code decoder: tracks E0/F0 prefixes and shift
// state, and holds the code of the currently pressed key.
module ps2_key_decoder
  import hack_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key_code,
  output logic        key_valid,
  output logic        frame_err
);

  logic [7:0] w_byte;
  logic       w_byte_stb;
  logic [7:0] w_hack;
  logic       r_ext, r_brk, r_lshift, r_rshift, r_valid;
  logic [7:0] r_key;
  logic [8:0] r_held;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .o_byte      (w_byte),
    .o_byte_stb  (w_byte_stb),
    .o_frame_err (frame_err)
  );

  assign w_hack = scan_to_hack(r_ext, w_byte, r_lshift | r_rshift);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_key    <= '0;
      r_held   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_byte_stb) begin
        if (w_byte == PS2_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == PS2_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (!r_ext && w_byte == SC_LSHIFT) begin
            r_lshift <= ~r_brk;
          end else if (!r_ext && w_byte == SC_RSHIFT) begin
            r_rshift <= ~r_brk;
          end else if (r_brk) begin
            // Only releasing the held key clears it; stale breaks are ignored.
            if (r_key != '0 && r_held == {r_ext, w_byte}) begin
              r_key   <= '0;
              r_valid <= 1'b1;
            end
          end else if (w_hack != '0) begin
            r_key   <= w_hack;
            r_held  <= {r_ext, w_byte};
            r_valid <= (w_hack != r_key);
          end
        end
      end
    end
  end

  assign key_code  = {8'h00, r_key};
  assign key_valid = r_valid;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench: bit-bangs PS/2 frames, expected key codes go into a scoreboard
// queue that a monitor drains on every key_valid pulse.
module tb_ps2_key_decoder;

  localparam int TMO  = 200;
  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] key_code;
  logic        key_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int exp_err_cnt = 0;
  int got_err_cnt = 0;
  logic [15:0] exp_q[$];

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cycles(HALF);
    ps2_clk = 1'b0;
    cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0,
                            input logic bad_stop = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1 ^ bad_stop);
    ps2_data = 1'b1;
    cycles(30);
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(i[0]);
    ps2_data = 1'b1;
  endtask

  task automatic expect_key(input int v);
    exp_q.push_back(16'(v));
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      cycles(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected key_valid pulses missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every key_valid pulse must match the next expected code.
  initial begin
    logic        prev_err;
    logic [15:0] e;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (key_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_key_valid: got key_code %0d, required no pulse", key_code);
        end else begin
          e = exp_q.pop_front();
          if (key_code !== e) begin
            errors++;
            $display("FAIL key_code_on_valid: got %0d, required %0d", key_code, e);
          end
        end
      end
      if (frame_err) begin
        got_err_cnt++;
        checks++;
        if (prev_err) begin
          errors++;
          $display("FAIL frame_err_width: got high 2+ cycles, required 1-cycle pulse");
        end
      end
      prev_err = frame_err;
    end
  end

  initial begin
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cycles(5);
    check("reset_key_code", key_code, 16'd0);
    check("reset_key_valid", {15'd0, key_valid}, 16'd0);
    check("reset_frame_err", {15'd0, frame_err}, 16'd0);
    reset = 1'b0;
    cycles(5);

    // 'a' make then break
    expect_key(97); send_frame(8'h1C);
    expect_key(0);  send_frame(8'hF0); send_frame(8'h1C);
    drain("a_make_break");

    // shifted 'A'; shift frames themselves must not pulse key_valid
    send_frame(8'h12);
    expect_key(65); send_frame(8'h1C);
    expect_key(0);  send_frame(8'hF0); send_frame(8'h1C);
    send_frame(8'hF0); send_frame(8'h12);
    drain("shift_A");

    // extended up arrow
    expect_key(131); send_frame(8'hE0); send_frame(8'h75);
    expect_key(0);   send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    drain("ext_up");

    // parity error: no key change, then a good frame
    exp_err_cnt++; send_frame(8'h1C, 1'b1, 1'b0);
    check("after_parity_err", key_code, 16'd0);
    expect_key(97); send_frame(8'h1C);
    drain("after_parity_err_a");

    // truncated frame abandoned by timeout
    send_partial(4);
    cycles(TMO + 100);
    check("after_timeout", key_code, 16'd97);
    expect_key(32); send_frame(8'h29);
    drain("after_timeout_space");

    // typematic repeat and break of a non-held key: no pulses
    send_frame(8'h29);
    send_frame(8'hF0); send_frame(8'h1C);
    check("repeat_hold", key_code, 16'd32);

    // right shift + '1' -> '!'
    send_frame(8'h59);
    expect_key(33); send_frame(8'h16);
    send_frame(8'hF0); send_frame(8'h59);
    expect_key(0); send_frame(8'hF0); send_frame(8'h16);
    drain("shift_digit");

    // F12, stop-bit error, then unmapped make leaves key held
    expect_key(152); send_frame(8'h07);
    exp_err_cnt++; send_frame(8'h29, 1'b0, 1'b1);
    send_frame(8'h0E);
    check("unmapped_hold", key_code, 16'd152);
    expect_key(0); send_frame(8'hF0); send_frame(8'h07);
    drain("f12_stop_err");

    // reset mid-frame while a key is held
    expect_key(97); send_frame(8'h1C);
    drain("pre_reset_a");
    send_partial(3);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);
    check("mid_frame_reset", key_code, 16'd0);
    expect_key(128); send_frame(8'h5A);
    drain("post_reset_enter");

    cycles(20);
    check("frame_err_count", 16'(got_err_cnt), 16'(exp_err_cnt));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
